mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Sequencing controller that shares one single-port, fixed-latency unified memory between the pipeline's instruction-fetch (IF) stage and its data-access (MEM) stage (lw/sw). It grants one requester at a time, drives the memory port, and returns the read data with a one-cycle ready pulse. It also produces the stall signals the hazard logic uses to freeze the IF stage and the MEM stage while their accesses are outstanding.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 2, cycles from a mem_en cycle to valid mem_rdata; legal range is 1 or more

Ports:
- clk  in  1  clock; all state updates on its rising edge
- rst  in  1  reset, synchronous, active-high
- if_req  in  1  fetch request; held until if_ready
- if_addr  in  ADDR_W  fetch address
- if_kill  in  1  discard the in-flight fetch (branch/jump redirect)
- if_rdata  out  DATA_W  fetched instruction, registered
- if_ready  out  1  one-cycle pulse; if_rdata is valid in that cycle
- d_req  in  1  data request; held until d_ready
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data, registered
- d_ready  out  1  one-cycle completion pulse
- stall_f  out  1  stall the IF stage
- stall_m  out  1  stall the MEM stage
- mem_en  out  1  memory access strobe, registered, one cycle per access
- mem_we  out  1  memory write enable, qualified by mem_en
- mem_addr  out  ADDR_W  memory address, registered
- mem_wdata  out  DATA_W  memory write data, registered
- mem_rdata  in  DATA_W  memory read data, valid exactly MEM_LAT cycles after the mem_en cycle

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- Arbitration is evaluated only in IDLE, with fixed priority d_req > if_req. The older instruction wins, and an active data access already freezes fetch, so starvation cannot occur.
- IDLE → ISSUE on any request. At the grant edge the block latches the owner, the address, the write data, and the write flag (d_we for a data grant, 0 for a fetch grant).
- ISSUE: mem_en=1 for exactly this cycle.
  - Write: next state is RESP.
  - Read: load cnt=MEM_LAT-1, next state is WAIT.
- WAIT: decrement cnt each cycle. When cnt==0, capture mem_rdata into the owner's rdata register and go to RESP.
- RESP:
  - Pulse the owner's ready for one cycle; next state is IDLE.
  - No grant is made in RESP, so a request still held during its own ready cycle is never re-granted.
- stall_f = if_req & ~if_ready. stall_m = d_req & ~d_ready. Both are combinational from state and inputs.
- if_kill:
  - If the current owner is fetch and if_kill is seen in ISSUE or WAIT, a kill flag is set.
  - The memory transaction still completes, but RESP suppresses if_ready and leaves if_rdata unchanged.
  - The flag clears on entry to IDLE. if_kill in IDLE or RESP, or during a data transaction, has no effect.
- A requester that drops req mid-transaction does not abort it; the ready pulse is still produced and is ignored.
- Loads and fetches update only their own rdata register. A store updates neither.

## Timing
- Reset: state=IDLE, cnt=0, kill=0. mem_en, mem_we, mem_addr, mem_wdata, if_rdata, d_rdata, if_ready and d_ready are all 0.
- Request first seen in IDLE at cycle T:
  - mem_en=1 at cycle T+1.
  - Read: ready at cycle T+2+MEM_LAT.
  - Write: ready at cycle T+2.
- Back-to-back throughput is one read per MEM_LAT+3 cycles and one write per 3 cycles.
- Simultaneous d_req and if_req in IDLE: data is granted. Fetch is granted in the IDLE cycle immediately after the data RESP, if still requested.
- rst mid-transaction:
  - Return to IDLE the next cycle with mem_en=0.
  - No ready pulse is produced for the abandoned access.
  - Any in-flight mem_rdata is ignored.
- Address/data inputs may change after the grant edge without effect.

## Structure
- Shared package riscv_mem_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, RESP)
  - the owner encoding (OWN_IF, OWN_D)
  - localparam CNT_W = $clog2(MEM_LAT+1)
- One sub-module is natural: lat_counter, a loadable down-counter with a zero flag, used for WAIT.

## Test plan
- MEM_LAT=2, if_req at cycle 0 with if_addr=0x10; memory returns 0x00500093 at cycle 3 → mem_en at cycle 1 with mem_addr=0x10; if_ready=1 and if_rdata=0x00500093 at cycle 4; stall_f=1 in cycles 0–3.
- d_req and if_req both high at cycle 0 (load from 0x100, returning 0xDEADBEEF) → data is granted first and d_ready=1 at cycle 4 with d_rdata=0xDEADBEEF; fetch mem_en at cycle 6; if_ready at cycle 9.
- Store with d_we=1, d_addr=0x200, d_wdata=0x12345678 at cycle 0 → mem_en=1, mem_we=1 and matching addr/data at cycle 1; d_ready at cycle 2; d_rdata and if_rdata unchanged.
- Fetch in progress, if_kill pulsed at cycle 2 → mem_en still issued, if_ready stays 0 at cycle 4, if_rdata unchanged; a new fetch granted at cycle 5 completes normally.
- rst asserted at cycle 2 of a load → cycle 3 is IDLE with all outputs 0; no d_ready ever; a load requested after reset completes with nominal latency.
- MEM_LAT=1 and MEM_LAT=5 regressions → read ready exactly MEM_LAT+2 cycles after the request cycle.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// Shared types for the IF/MEM unified-memory port arbiter.
// Holds the FSM state encoding, the owner encoding and the latency-counter width.
package riscv_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    localparam int unsigned MEM_LAT_DEFAULT = 2;
    localparam int unsigned CNT_W = $clog2(MEM_LAT_DEFAULT + 1);

    // A package constant cannot follow a module parameter, so instances size their counter here.
    function automatic int unsigned cnt_width(input int unsigned lat);
        return (lat < 1) ? 1 : $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_lat_counter.sv
// Loadable down-counter with a zero flag.
// It times the WAIT phase of a memory read.
module lat_counter
    import riscv_mem_pkg::*;
#(
    parameter int unsigned W = CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between instruction fetch and data access.
// Fixed priority for data, registered memory strobe and ready pulses, and kill handling for redirected fetches.
module mem_port_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_kill,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              stall_f,
    output logic              stall_m,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned CW = cnt_width(MEM_LAT);

    arb_state_t state, state_n;
    owner_t     owner;
    logic       we_q;
    logic       kill;
    logic       grant, grant_d;
    logic       cnt_load, cnt_dec, cnt_zero;
    logic       capture;
    logic       kill_hit, kill_now;

    lat_counter #(.W(CW)) u_lat_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (CW'(MEM_LAT - 1)),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_n  = state;
        grant    = 1'b0;
        grant_d  = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        capture  = 1'b0;
        unique case (state)
            IDLE: begin
                if (d_req || if_req) begin
                    grant   = 1'b1;
                    grant_d = d_req;
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                if (we_q) begin
                    state_n = RESP;
                end else begin
                    cnt_load = 1'b1;
                    state_n  = WAIT;
                end
            end
            WAIT: begin
                if (cnt_zero) begin
                    capture = 1'b1;
                    state_n = RESP;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            RESP: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // A kill arriving in the capture cycle itself must still suppress the response.
    assign kill_hit = (owner == OWN_IF) && ((state == ISSUE) || (state == WAIT)) && if_kill;
    assign kill_now = kill || kill_hit;

    assign stall_f = if_req && !if_ready;
    assign stall_m = d_req && !d_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= OWN_IF;
            we_q      <= 1'b0;
            kill      <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            if_ready  <= 1'b0;
            d_ready   <= 1'b0;
        end else begin
            state  <= state_n;
            mem_en <= grant;
            mem_we <= grant && grant_d && d_we;
            if (grant) begin
                owner    <= grant_d ? OWN_D : OWN_IF;
                we_q     <= grant_d && d_we;
                mem_addr <= grant_d ? d_addr : if_addr;
                if (grant_d) begin
                    mem_wdata <= d_wdata;
                end
            end
            if (state == RESP) begin
                kill <= 1'b0;
            end else if (kill_hit) begin
                kill <= 1'b1;
            end
            if (capture) begin
                if (owner == OWN_D) begin
                    d_rdata <= mem_rdata;
                end else if (!kill_now) begin
                    if_rdata <= mem_rdata;
                end
            end
            if_ready <= (state_n == RESP) && (owner == OWN_IF) && !kill_now;
            d_ready  <= (state_n == RESP) && (owner == OWN_D);
        end
    end

endmodule
